// File: rtl/code_lock_pkg.sv
// Shared types and default constants for the code lock.
package code_lock_pkg;

  localparam int unsigned KEY_W = 8;

  localparam logic [KEY_W-1:0] DEFAULT_KEY_C    = 8'hA5;
  localparam int unsigned      MAX_FAILS_C      = 3;
  localparam int unsigned      LOCKOUT_CYCLES_C = 16;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

endpackage

// File: rtl/code_lock_cmp.sv
// Equality comparator between the captured attempt and the stored secret.
module code_lock_cmp
  import code_lock_pkg::*;
(
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             equals
);

  assign equals = (a == b);

endmodule

// File: rtl/code_lock.sv
// Keypad-style code lock: one-cycle compare, consecutive-failure lockout, reprogrammable secret.
module code_lock
  import code_lock_pkg::*;
#(
  parameter logic [KEY_W-1:0] DEFAULT_KEY    = DEFAULT_KEY_C,
  parameter int unsigned      MAX_FAILS      = MAX_FAILS_C,
  parameter int unsigned      LOCKOUT_CYCLES = LOCKOUT_CYCLES_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  input  logic             prog,
  input  logic             lock_cmd,
  output logic             ready,
  output logic             unlocked,
  output logic             alarm,
  output logic             ok_pulse,
  output logic             err_pulse,
  output logic [1:0]       fail_count
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0] FAIL_LIM  = 3'(MAX_FAILS);
  localparam logic [1:0] FAIL_SAT  = 2'(MAX_FAILS);

  state_t           state;
  logic [KEY_W-1:0] secret;
  logic [KEY_W-1:0] attempt;
  logic [7:0]       timer;
  logic             match;
  logic [2:0]       fail_next;

  code_lock_cmp u_cmp (
    .a      (attempt),
    .b      (secret),
    .equals (match)
  );

  // Widened so the limit test never wraps when fail_count is already 3.
  assign fail_next = {1'b0, fail_count} + 3'd1;

  assign ready    = (state == LOCKED) || (state == UNLOCKED);
  assign unlocked = (state == UNLOCKED);
  assign alarm    = (state == LOCKOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      secret     <= DEFAULT_KEY;
      attempt    <= '0;
      timer      <= '0;
      fail_count <= '0;
      ok_pulse   <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      unique case (state)
        LOCKED: begin
          if (key_valid) begin
            attempt <= key_in;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (match) begin
            state      <= UNLOCKED;
            fail_count <= '0;
            ok_pulse   <= 1'b1;
          end else begin
            err_pulse <= 1'b1;
            if (fail_next >= FAIL_LIM) begin
              state      <= LOCKOUT;
              timer      <= LOCK_LAST;
              fail_count <= FAIL_SAT;
            end else begin
              state      <= LOCKED;
              fail_count <= fail_next[1:0];
            end
          end
        end
        UNLOCKED: begin
          // Programming and relock in the same cycle both apply.
          if (key_valid && prog) secret <= key_in;
          if (lock_cmd) state <= LOCKED;
        end
        LOCKOUT: begin
          if (timer == 8'd0) begin
            state      <= LOCKED;
            fail_count <= '0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Directed bench for code_lock with hand-computed expectations.
module tb_code_lock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_in;
  logic       key_valid;
  logic       prog;
  logic       lock_cmd;
  logic       ready;
  logic       unlocked;
  logic       alarm;
  logic       ok_pulse;
  logic       err_pulse;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  code_lock dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .prog       (prog),
    .lock_cmd   (lock_cmd),
    .ready      (ready),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .ok_pulse   (ok_pulse),
    .err_pulse  (err_pulse),
    .fail_count (fail_count)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ready, input logic e_unl,
                            input logic e_alarm, input logic e_ok, input logic e_err,
                            input logic [1:0] e_fc);
    check_eq({tag, ".ready"},      8'(ready),      8'(e_ready));
    check_eq({tag, ".unlocked"},   8'(unlocked),   8'(e_unl));
    check_eq({tag, ".alarm"},      8'(alarm),      8'(e_alarm));
    check_eq({tag, ".ok_pulse"},   8'(ok_pulse),   8'(e_ok));
    check_eq({tag, ".err_pulse"},  8'(err_pulse),  8'(e_err));
    check_eq({tag, ".fail_count"}, 8'(fail_count), 8'(e_fc));
  endtask

  // Strobe a key from LOCKED; returns at the negedge two cycles after the strobe.
  task automatic attempt_key(input string tag, input logic [7:0] k, input logic e_ok,
                             input logic [1:0] e_fc, input logic e_lockout);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check_eq({tag, ".check_ready"}, 8'(ready), 8'd0);
    @(negedge clk);
    check_outs(tag, !e_lockout, e_ok, e_lockout, e_ok, !e_ok, e_fc);
  endtask

  task automatic relock(input string tag);
    @(negedge clk);
    lock_cmd = 1'b1;
    @(negedge clk);
    lock_cmd = 1'b0;
    check_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = 8'h00;
    key_valid = 1'b0;
    prog      = 1'b0;
    lock_cmd  = 1'b0;

    repeat (2) @(negedge clk);
    check_outs("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Correct default key
    attempt_key("unlock_a5", 8'hA5, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    check_outs("ok_one_cycle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    relock("relock1");

    // Two wrong keys then the right one
    attempt_key("wrong_00", 8'h00, 1'b0, 2'd1, 1'b0);
    @(negedge clk);
    check_eq("err_one_cycle", 8'(err_pulse), 8'd0);
    attempt_key("wrong_01", 8'h01, 1'b0, 2'd2, 1'b0);
    attempt_key("unlock_after_2", 8'hA5, 1'b1, 2'd0, 1'b0);
    relock("relock2");

    // Three wrong keys -> lockout of 16 cycles; a correct strobe inside is ignored
    attempt_key("lk_w1", 8'h11, 1'b0, 2'd1, 1'b0);
    attempt_key("lk_w2", 8'h22, 1'b0, 2'd2, 1'b0);
    attempt_key("lk_w3", 8'h33, 1'b0, 2'd3, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      key_in    = 8'hA5;
      key_valid = (i == 5);
      check_outs($sformatf("lockout_c%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    end
    @(negedge clk);
    key_valid = 1'b0;
    check_outs("lockout_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check_outs("lockout_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    attempt_key("unlock_post_lockout", 8'hA5, 1'b1, 2'd0, 1'b0);

    // Program new secret together with relock
    @(negedge clk);
    key_in    = 8'h3C;
    key_valid = 1'b1;
    prog      = 1'b1;
    lock_cmd  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    prog      = 1'b0;
    lock_cmd  = 1'b0;
    check_outs("prog_lock", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    attempt_key("old_key_fails", 8'hA5, 1'b0, 2'd1, 1'b0);
    attempt_key("new_key_opens", 8'h3C, 1'b1, 2'd0, 1'b0);
    relock("relock3");

    // Reset in lockout cycle 5 restores default secret
    attempt_key("rs_w1", 8'h01, 1'b0, 2'd1, 1'b0);
    attempt_key("rs_w2", 8'h02, 1'b0, 2'd2, 1'b0);
    attempt_key("rs_w3", 8'h03, 1'b0, 2'd3, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("pre_reset_alarm", 8'(alarm), 8'd1);
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    #2;
    rst_n = 1'b1;
    attempt_key("secret_not_3c", 8'h3C, 1'b0, 2'd1, 1'b0);
    attempt_key("secret_back_a5", 8'hA5, 1'b1, 2'd0, 1'b0);
    relock("relock4");

    // Reset during CHECK aborts without a pulse
    @(negedge clk);
    key_in    = 8'h00;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_outs("reset_in_check", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("after_check_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Plain strobe while unlocked is ignored
    attempt_key("unlock_for_ff", 8'hA5, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    key_in    = 8'hFF;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check_outs("ignore_ff_1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check_outs("ignore_ff_2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    relock("relock5");
    attempt_key("ff_not_secret", 8'hFF, 1'b0, 2'd1, 1'b0);
    attempt_key("a5_still_secret", 8'hA5, 1'b1, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
